uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receive half of the XBee serial link: turns the asynchronous rx line into bytes.
//  Frame format: 8N1, LSB first, line idles high.
//  Generates its own oversample tick internally.
//  Presents each byte on a valid/ack handshake to the host logic, with frame-error and overrun flags.
// PARAMETERS
//  CLKFREQ    100_000_000  system clock frequency in Hz
//  BAUD       9600         line baud rate
//  OVERSAMPLE 16           ticks per bit; even, >=4; CLKFREQ/(BAUD*OVERSAMPLE) must be >=2
//  DATA_BITS  8            data bits per frame
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  rst        in   1          synchronous, active-low reset (0 = reset)
//  rx         in   1          serial input, asynchronous to clk
//  data       out  DATA_BITS  last accepted byte; held while valid=1
//  valid      out  1          data holds an unconsumed byte
//  ack        in   1          consumer takes data; valid clears on the next edge
//  frame_err  out  1          1-clk pulse: stop bit sampled low
//  overrun    out  1          1-clk pulse: byte completed while valid=1 and ack=0; new byte dropped
//  busy       out  1          state != IDLE
// BEHAVIOUR
//  Reset (rst=0 at posedge)
//   - data=0, valid=0, frame_err=0, overrun=0, busy=0
//   - state=IDLE, tick counter=0, sync flops=1
//   - Applies mid-frame too; the partial byte is discarded.
//  Synchronisation
//   - rx passes through 2 flops to give rx_s; all decisions use rx_s.
//  Tick generation
//   - TOP = CLKFREQ/(BAUD*OVERSAMPLE) - 1 (integer division).
//   - The counter runs 0..TOP only while state != IDLE; tick=1 when the counter equals TOP.
//   - The counter is cleared on start detection.
//   - Default: 651 clk per tick.
//  Tick count and bit index
//   - tcnt counts ticks within the current bit.
//   - bidx counts data bits, 0..DATA_BITS-1.
//  State machine
//   - IDLE: rx_s==0 -> START; clear tcnt and the tick counter.
//   - START: at tick number OVERSAMPLE/2 (mid start bit), sample rx_s:
//       0 -> DATA, tcnt=0, bidx=0
//       1 -> IDLE (glitch; no flags raised)
//   - DATA: every OVERSAMPLE ticks, shift rx_s into the shift register MSB, shifting right,
//     so the first bit received lands in data[0].
//     After bit DATA_BITS-1 is sampled -> STOP.
//   - STOP: after OVERSAMPLE ticks, sample rx_s:
//       1 -> deliver, then IDLE
//       0 -> pulse frame_err, drop the byte, go to BRK
//   - BRK: wait for rx_s==1, then IDLE. This prevents a held-low line from retriggering START.
//  Delivery (the cycle after the stop sample)
//   - valid=0, or ack=1 in the same cycle: data<=shift register, valid<=1, no overrun.
//   - valid=1 and ack=0: data unchanged, valid stays 1, overrun pulses for 1 clk.
//  ack handling
//   - ack with valid=1 and no delivery that cycle: valid<=0 next edge; data unchanged.
//   - ack with valid=0: ignored.
//  Latency
//   - valid rises 2 (sync) + 1 clk after the stop-bit mid-point, about 9.5 bit times
//     after the falling edge of the start bit.
//  Width rules
//   - Tick counter: 32 bits.
//   - tcnt: clog2(OVERSAMPLE) bits; wraps to 0 at each bit boundary.
//   - bidx: clog2(DATA_BITS)+1 bits.
// STRUCTURE
//  Shared package (uart_pkg)
//   - state encoding localparams: IDLE, START, DATA, STOP, BRK
//   - default frame constants: DATA_BITS=8, OVERSAMPLE=16
//  Sub-module
//   - one: sync2, the 2-flop synchronizer (reset value 1), reusable by the transmit side for cts.
//  Everything else lives inline: tick counter, FSM, shift register, output registers.
// TESTING (CLKFREQ=1_600_000, BAUD=10_000 -> 10 clk/tick, 160 clk/bit)
//  1. Frame 0xA5, ack held 0 -> valid=1, data=0xA5 about 1520 clk after the start edge.
//     Then ack one cycle -> valid=0 the next clk.
//  2. rx low for 40 clk, then high -> busy rises and falls; valid, frame_err and overrun stay 0.
//  3. Frame 0x3C with stop bit 0, rx held low 500 clk -> one frame_err pulse, valid=0, state BRK.
//     Then rx high, frame 0x3C -> data=0x3C.
//  4. Frames 0x11 then 0x22 back-to-back, no ack -> data=0x11 held, one overrun pulse at the 0x22 stop.
//  5. As 4, but ack=1 in the 0x22 delivery cycle -> data=0x22, valid=1, overrun=0.
//  6. rst=0 for 1 clk mid-DATA of a frame -> all outputs 0 next edge.
//     Then frame 0x7E -> data=0x7E, valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
//
// Purpose: constants shared by the UART receive and transmit sides.
// Contents: FSM state encodings and default frame geometry.

package uart_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_START = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_STOP  = 3'd3;
  localparam logic [STATE_W-1:0] ST_BRK   = 3'd4;

  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for asynchronous single-bit inputs
//
// Purpose: bring an asynchronous level into the clk domain. Resets to 1 so an
//          idle-high serial or flow-control line reads idle straight out of reset.
// Ports:
//   clk  in   system clock
//   rst  in   synchronous active-low reset
//   d_i  in   asynchronous input
//   q_o  out  synchronized output

module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with internal oversample tick and valid/ack output
//
// Purpose: deserialise an idle-high, LSB-first serial line into bytes.
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-low reset
//   rx         in   serial input, asynchronous to clk
//   data       out  last accepted byte, held while valid=1
//   valid      out  data holds an unconsumed byte
//   ack        in   consumer takes data
//   frame_err  out  1-clk pulse: stop bit sampled low
//   overrun    out  1-clk pulse: byte completed while valid=1 and ack=0, byte dropped
//   busy       out  receiver is not idle

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKFREQ    = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int DATA_BITS  = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;

  localparam logic [31:0]   TOP    = 32'(CLKFREQ / (BAUD * OVERSAMPLE) - 1);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rx_s;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  logic [STATE_W-1:0]   state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 deliver_q, deliver_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 tick;

  // The tick counter is held at zero in IDLE so every frame starts phase-aligned
  // to its own start edge.
  assign tick = (state_q != ST_IDLE) && (cnt_q == TOP);

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == ST_IDLE || tick) ? '0 : cnt_q + 32'd1;
    tcnt_d      = tcnt_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;

    if (tick) begin
      tcnt_d = (tcnt_q == T_LAST) ? '0 : tcnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          tcnt_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // Mid start bit: a line already back high was a glitch.
        if (tick && tcnt_q == T_HALF) begin
          tcnt_d  = '0;
          bidx_d  = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick && tcnt_q == T_LAST) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bidx_d  = bidx_q + 1'b1;
          if (bidx_q == B_LAST) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick && tcnt_q == T_LAST) begin
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_BRK;
          end
        end
      end
      ST_BRK: begin
        // Hold off until the line returns high so a break is not read as frames.
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A same-cycle ack frees the holding register for the incoming byte.
    if (deliver_q) begin
      if (!valid_q || ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at 10 clk/tick, 160 clk/bit

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int rise_cyc = -1;
  logic valid_prev = 1'b0;

  uart_rx #(
    .CLKFREQ    (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    if (overrun === 1'b1) ov_cnt = ov_cnt + 1;
    if (valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
    valid_prev = valid;
  end

  // Drives one full 10-bit frame, 160 clk per bit; ack pulses for one cycle at
  // offset ack_rel from the start edge when ack_rel >= 0.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ack_rel,
                            output int s);
    logic [9:0] fb;
    fb = {stop_bit, b, 1'b0};
    @(posedge clk); #1;
    s = cyc;
    for (int c = 0; c < 1600; c++) begin
      rx = fb[c / 160];
      if (ack_rel >= 0) ack = (c == ack_rel);
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_ack();
    @(posedge clk); #1;
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    int s, fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    ack = 1'b0;
    send_frame(8'hA5, 1'b1, -1, s);
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", valid); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_data: got %h want a5", data); end
    n_checks++; if (rise_cyc - s < 1520 || rise_cyc - s > 1528) begin
      n_fail++; $display("FAIL basic_latency: got %0d clk want 1520..1528", rise_cyc - s); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL basic_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL basic_overrun: got %0d pulses want 0", ov_cnt - ov0); end
    pulse_ack();
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack_valid: got %b want 0", valid); end
    n_checks++; if (data !== 8'hA5) begin n_fail++; $display("FAIL basic_ack_data: got %h want a5", data); end
  endtask

  task automatic test_glitch();
    int fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    repeat (20) @(posedge clk);
    #1 rx = 1'b1;
    repeat (150) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b want 0", valid); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL glitch_overrun: got %0d pulses want 0", ov_cnt - ov0); end
  endtask

  task automatic test_frame_err();
    int s, fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, -1, s);
    repeat (500) @(posedge clk);
    @(negedge clk);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b want 0", valid); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_brk: got %b want 1", busy); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL ferr_overrun: got %0d pulses want 0", ov_cnt - ov0); end
    rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_idle: got %b want 0", busy); end
    repeat (50) @(posedge clk);
    send_frame(8'h3C, 1'b1, -1, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ferr_recover_valid: got %b want 1", valid); end
    n_checks++; if (data !== 8'h3C) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 3c", data); end
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_recover_pulses: got %0d want 1", fe_cnt - fe0); end
    pulse_ack();
  endtask

  task automatic test_back_to_back();
    int s, fe0, ov0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1, s);
    send_frame(8'h22, 1'b1, -1, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h11) begin n_fail++; $display("FAIL b2b_data: got %h want 11", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b want 1", valid); end
    n_checks++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses want 1", ov_cnt - ov0); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
    pulse_ack();
  endtask

  // Delivery edge is 1524 clk after the start edge, so ack is raised at offset 1523.
  task automatic test_ack_collision();
    int s, ov0;
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1, s);
    send_frame(8'h22, 1'b1, 1523, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h22) begin n_fail++; $display("FAIL collide_data: got %h want 22", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL collide_valid: got %b want 1", valid); end
    n_checks++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL collide_overrun: got %0d pulses want 0", ov_cnt - ov0); end
  endtask

  task automatic test_reset_mid();
    int s;
    @(negedge clk);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_valid: got %b want 1", valid); end
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (320) @(posedge clk);
    #1 rx = 1'b1;
    repeat (80) @(posedge clk);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_pre: got %b want 1", busy); end
    rst = 1'b0;
    rx  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h want 00", data); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err: got %b want 0", frame_err); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun: got %b want 0", overrun); end
    rst = 1'b1;
    repeat (50) @(posedge clk);
    send_frame(8'h7E, 1'b1, -1, s);
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++; if (data !== 8'h7E) begin n_fail++; $display("FAIL midrst_after_data: got %h want 7e", data); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL midrst_after_valid: got %b want 1", valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_ack_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
